// File: rtl/kbd_msg_buffer_pkg.sv
// Shared types, ASCII constants and the keystroke classifier for the keyboard message buffer.
package kbd_msg_pkg;

   typedef logic [7:0] char_t;

   localparam char_t ASCII_BS       = 8'h08;
   localparam char_t ASCII_CR       = 8'h0D;
   localparam char_t ASCII_SPACE    = 8'h20;
   localparam char_t ASCII_PRINT_LO = 8'h20;
   localparam char_t ASCII_PRINT_HI = 8'h7E;

   typedef enum logic {IDLE, PEND} msg_state_t;

   typedef enum logic [1:0] {CL_PRINT, CL_BS, CL_CR, CL_OTHER} char_class_t;

   function automatic char_class_t char_class(input char_t c);
      if (c >= ASCII_PRINT_LO && c <= ASCII_PRINT_HI) return CL_PRINT;
      else if (c == ASCII_BS)                         return CL_BS;
      else if (c == ASCII_CR)                         return CL_CR;
      else                                            return CL_OTHER;
   endfunction

endpackage

// File: rtl/kbd_msg_buffer_line_editor.sv
// Editable line buffer: applies PRINT/BS keystrokes, flags discarded keys and requests commits.
// KBD_AUTOSEND_EN: a full buffer keeps requesting a commit until it is granted.
module kbd_line_editor
   import kbd_msg_pkg::*;
#(
   parameter int    MSG_CHARS = 16,
   parameter char_t PAD_CHAR  = ASCII_SPACE,
   localparam int   LW        = $clog2(MSG_CHARS + 1)
) (
   input  logic                   clock_65mhz,
   input  logic                   reset_n,
   input  logic [7:0]             ascii,
   input  logic                   char_rdy,
   input  logic                   clear,
   output logic                   commit_req,
   output logic [MSG_CHARS*8-1:0] edit_string,
   output logic [LW-1:0]          edit_len,
   output logic                   drop
);

   localparam logic [LW-1:0] FULL = LW'(MSG_CHARS);

   char_t         slots   [MSG_CHARS];
   char_t         slots_n [MSG_CHARS];
   logic [LW-1:0] len_q;
   logic [LW-1:0] len_n;
   logic          drop_n;
   char_class_t   cls;

   assign cls = char_class(ascii);

`ifdef KBD_AUTOSEND_EN
   assign commit_req = (char_rdy && cls == CL_CR && len_q != '0) || (len_q == FULL);
`else
   assign commit_req = char_rdy && cls == CL_CR && len_q != '0;
`endif

   // A granted commit clears first, so a keystroke in the same cycle edits the fresh line.
   always_comb begin
      len_n  = clear ? '0 : len_q;
      drop_n = 1'b0;
      for (int i = 0; i < MSG_CHARS; i++) slots_n[i] = clear ? PAD_CHAR : slots[i];
      if (char_rdy) begin
         case (cls)
            CL_PRINT: begin
               if (len_n != FULL) begin
                  for (int i = 0; i < MSG_CHARS; i++)
                     if (LW'(i) == len_n) slots_n[i] = ascii;
                  len_n = len_n + 1'b1;
               end else begin
                  drop_n = 1'b1;
               end
            end
            CL_BS: begin
               if (len_n != '0) begin
                  for (int i = 0; i < MSG_CHARS; i++)
                     if (LW'(i) == len_n - 1'b1) slots_n[i] = PAD_CHAR;
                  len_n = len_n - 1'b1;
               end
            end
            CL_CR:   drop_n = (len_q != '0) && !clear;
            default: drop_n = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock_65mhz or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MSG_CHARS; i++) slots[i] <= PAD_CHAR;
         len_q <= '0;
         drop  <= 1'b0;
      end else begin
         for (int i = 0; i < MSG_CHARS; i++) slots[i] <= slots_n[i];
         len_q <= len_n;
         drop  <= drop_n;
      end
   end

   for (genvar g = 0; g < MSG_CHARS; g++) begin : g_pack
      assign edit_string[(MSG_CHARS-g)*8-1 -: 8] = slots[g];
   end

   assign edit_len = len_q;

endmodule

// File: rtl/kbd_msg_buffer.sv
// Keyboard line buffer with committed-message register and valid/ready handoff to the laser path.
// Optional build macro: KBD_AUTOSEND_EN (auto-commit when the line fills).
module kbd_msg_buffer
   import kbd_msg_pkg::*;
#(
   parameter int    MSG_CHARS = 16,
   parameter char_t PAD_CHAR  = ASCII_SPACE,
   localparam int   LW        = $clog2(MSG_CHARS + 1)
) (
   input  logic                   clock_65mhz,
   input  logic                   reset_n,
   input  logic [7:0]             ascii,
   input  logic                   char_rdy,
   input  logic                   msg_ready,
   output logic                   msg_valid,
   output logic [MSG_CHARS*8-1:0] msg_string,
   output logic [LW-1:0]          msg_len,
   output logic [MSG_CHARS*8-1:0] edit_string,
   output logic [LW-1:0]          edit_len,
   output logic                   drop
);

   msg_state_t state;
   logic       commit_req;
   logic       grant;

   // The output slot is free when idle, or when the pending message leaves this cycle.
   assign grant = commit_req && (state == IDLE || msg_ready);

   kbd_line_editor #(
      .MSG_CHARS (MSG_CHARS),
      .PAD_CHAR  (PAD_CHAR)
   ) u_editor (
      .clock_65mhz (clock_65mhz),
      .reset_n     (reset_n),
      .ascii       (ascii),
      .char_rdy    (char_rdy),
      .clear       (grant),
      .commit_req  (commit_req),
      .edit_string (edit_string),
      .edit_len    (edit_len),
      .drop        (drop)
   );

   always_ff @(posedge clock_65mhz or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         msg_valid  <= 1'b0;
         msg_string <= {MSG_CHARS{PAD_CHAR}};
         msg_len    <= '0;
      end else if (grant) begin
         state      <= PEND;
         msg_valid  <= 1'b1;
         msg_string <= edit_string;
         msg_len    <= edit_len;
      end else if (state == PEND && msg_ready) begin
         state      <= IDLE;
         msg_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kbd_msg_buffer.sv
// Directed-vector bench for kbd_msg_buffer at MSG_CHARS = 16.
module tb_kbd_msg_buffer;

   localparam int N  = 16;
   localparam int W  = N * 8;
   localparam int LW = $clog2(N + 1);

   logic          clock_65mhz = 1'b0;
   logic          reset_n     = 1'b0;
   logic [7:0]    ascii       = 8'h00;
   logic          char_rdy    = 1'b0;
   logic          msg_ready   = 1'b0;
   logic          msg_valid;
   logic [W-1:0]  msg_string;
   logic [LW-1:0] msg_len;
   logic [W-1:0]  edit_string;
   logic [LW-1:0] edit_len;
   logic          drop;

   int n_checks = 0;
   int n_fail   = 0;
   int drops;

   kbd_msg_buffer #(.MSG_CHARS(N), .PAD_CHAR(8'h20)) dut (
      .clock_65mhz (clock_65mhz),
      .reset_n     (reset_n),
      .ascii       (ascii),
      .char_rdy    (char_rdy),
      .msg_ready   (msg_ready),
      .msg_valid   (msg_valid),
      .msg_string  (msg_string),
      .msg_len     (msg_len),
      .edit_string (edit_string),
      .edit_len    (edit_len),
      .drop        (drop)
   );

   always #5 clock_65mhz = ~clock_65mhz;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input string s);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[(N-i)*8-1 -: 8] = (i < s.len()) ? s[i] : 8'h20;
      return v;
   endfunction

   // Called at a falling edge; presents one keystroke for one cycle.
   task automatic send(input logic [7:0] c);
      ascii    = c;
      char_rdy = 1'b1;
      @(negedge clock_65mhz);
      char_rdy = 1'b0;
   endtask

   task automatic release_msg();
      msg_ready = 1'b1;
      @(negedge clock_65mhz);
      msg_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clock_65mhz);
      check("rst_valid", W'(msg_valid), W'(0));
      check("rst_msg_len", W'(msg_len), W'(0));
      check("rst_edit_len", W'(edit_len), W'(0));
      check("rst_msg_string", msg_string, pack(""));
      check("rst_edit_string", edit_string, pack(""));
      check("rst_drop", W'(drop), W'(0));
      reset_n = 1'b1;
      @(negedge clock_65mhz);

      // "HI" + CR
      send("H"); send("I");
      check("hi_edit", edit_string, pack("HI"));
      send(8'h0D);
      check("hi_valid", W'(msg_valid), W'(1));
      check("hi_msg", msg_string, pack("HI"));
      check("hi_len", W'(msg_len), W'(2));
      check("hi_edit_len", W'(edit_len), W'(0));
      check("hi_drop", W'(drop), W'(0));
      release_msg();
      check("hi_released", W'(msg_valid), W'(0));
      check("hi_hold", msg_string, pack("HI"));

      // backspace at empty, then "AB" BS "C"
      send(8'h08);
      check("bs0_len", W'(edit_len), W'(0));
      check("bs0_drop", W'(drop), W'(0));
      check("bs0_edit", edit_string, pack(""));
      send("A"); send("B"); send(8'h08); send("C");
      check("ac_edit", edit_string, pack("AC"));
      send(8'h0D);
      check("ac_msg", msg_string, pack("AC"));
      check("ac_len", W'(msg_len), W'(2));
      release_msg();

      // 17 printable characters
      drops = 0;
      for (int i = 0; i < 17; i++) begin
         send(8'h41 + 8'(i));
         drops += int'(drop);
      end
`ifdef KBD_AUTOSEND_EN
      check("full_drops", W'(drops), W'(0));
      check("auto_valid", W'(msg_valid), W'(1));
      check("auto_len", W'(msg_len), W'(16));
      check("auto_msg", msg_string, pack("ABCDEFGHIJKLMNOP"));
      check("auto_edit_len", W'(edit_len), W'(1));
      check("auto_edit", edit_string, pack("Q"));
      send(8'h08);
`else
      check("full_drops", W'(drops), W'(1));
      check("full_last_drop", W'(drop), W'(1));
      check("full_len", W'(edit_len), W'(16));
      check("full_edit", edit_string, pack("ABCDEFGHIJKLMNOP"));
      send(8'h0D);
      check("full_msg_len", W'(msg_len), W'(16));
      check("full_msg", msg_string, pack("ABCDEFGHIJKLMNOP"));
`endif
      release_msg();

      // busy slot: CR drops, then ready + CR together
      send("X"); send(8'h0D);
      check("x_valid", W'(msg_valid), W'(1));
      send("Y"); send(8'h0D);
      check("busy_drop", W'(drop), W'(1));
      check("busy_msg", msg_string, pack("X"));
      check("busy_edit_len", W'(edit_len), W'(1));
      ascii = 8'h0D; char_rdy = 1'b1; msg_ready = 1'b1;
      @(negedge clock_65mhz);
      char_rdy = 1'b0; msg_ready = 1'b0;
      check("b2b_valid", W'(msg_valid), W'(1));
      check("b2b_msg", msg_string, pack("Y"));
      check("b2b_len", W'(msg_len), W'(1));
      check("b2b_edit_len", W'(edit_len), W'(0));

      // OTHER keystroke and CR on empty line
      send("Z"); send(8'h1B);
      check("other_drop", W'(drop), W'(1));
      check("other_len", W'(edit_len), W'(1));
      send(8'h08); send(8'h0D);
      check("cr0_drop", W'(drop), W'(0));
      check("cr0_msg", msg_string, pack("Y"));
      check("cr0_valid", W'(msg_valid), W'(1));

      // asynchronous reset while pending with a partial line
      send("1"); send("2"); send("3"); send("4"); send("5");
      check("pre_rst_len", W'(edit_len), W'(5));
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid", W'(msg_valid), W'(0));
      check("arst_edit_len", W'(edit_len), W'(0));
      check("arst_msg_len", W'(msg_len), W'(0));
      check("arst_msg", msg_string, pack(""));
      check("arst_edit", edit_string, pack(""));
      @(negedge clock_65mhz);
      reset_n = 1'b1;
      @(negedge clock_65mhz);
      send("Q");
      check("post_rst_len", W'(edit_len), W'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/kbd_msg_buffer.md
Name: kbd_msg_buffer

Overview:
- Parametrised successor to the fixed 16-character keyboard export block.
- Accumulates ASCII characters from the PS/2 ASCII decoder into an editable line buffer of MSG_CHARS characters, with backspace support.
- On Enter, commits the line to an output message register and offers it to the laser transmit path over a valid/ready handshake.
- Sits between ps2_ascii_input and the outgoing-message framer.

Parameters:
- MSG_CHARS, 16, characters per message; legal range 2..64.
- PAD_CHAR, 8'h20, fill value for unused character slots.

Ports:
- clock_65mhz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ascii  in  8  character from the decoder; qualified by char_rdy.
- char_rdy  in  1  one-cycle strobe, new character present.
- msg_ready  in  1  downstream accepts the message.
- msg_valid  out  1  committed message available.
- msg_string  out  MSG_CHARS*8  committed message; character 0 in bits [MSG_CHARS*8-1 -: 8], character i in bits [(MSG_CHARS-i)*8-1 -: 8].
- msg_len  out  LW  committed character count; LW = $clog2(MSG_CHARS+1).
- edit_string  out  MSG_CHARS*8  live edit buffer, same packing as msg_string, for display.
- edit_len  out  LW  live character count.
- drop  out  1  one-cycle pulse when a keystroke is discarded.

Behaviour:
- Reset (async assert, sync release): all slots of edit_string and msg_string = PAD_CHAR; edit_len = 0; msg_len = 0; msg_valid = 0; drop = 0; state = IDLE.
- Character classes, evaluated only when char_rdy = 1:
  - PRINT: 8'h20..8'h7E.
  - BS: 8'h08.
  - CR: 8'h0D.
  - OTHER: anything else.
- All effects are registered: char_rdy at cycle t -> outputs updated at t+1.
- PRINT with edit_len < MSG_CHARS: slot[edit_len] <= ascii; edit_len += 1.
- PRINT with edit_len == MSG_CHARS: discarded; drop pulses.
- BS with edit_len > 0: slot[edit_len-1] <= PAD_CHAR; edit_len -= 1.
- BS with edit_len == 0: no-op; no drop.
- OTHER: discarded; drop pulses.
- CR with edit_len == 0: ignored; no drop.
- CR with edit_len > 0: commit if the output slot is free (see below), else discarded with drop; the edit buffer is kept.
- Commit: msg_string <= edit_string; msg_len <= edit_len; msg_valid <= 1; edit buffer reset to all PAD_CHAR; edit_len <= 0. All of these take effect in the same cycle.
- State machine:
  - IDLE (msg_valid = 0): CR commits -> PEND.
  - PEND (msg_valid = 1): msg_string and msg_len are held stable.
  - PEND, msg_ready = 1 and no commit this cycle: msg_valid <= 0 -> IDLE.
  - PEND, msg_ready = 1 and CR commit in the same cycle: the new message loads, msg_valid stays 1, remain in PEND. This gives back-to-back transfers without a bubble.
  - PEND, msg_ready = 0 and CR: drop; edit buffer unchanged.
- Editing (PRINT/BS) continues normally in both states.
- msg_ready is ignored in IDLE.
- Reset mid-operation: everything returns to reset values immediately. A pending message is lost and msg_valid deasserts asynchronously.

Optional Feature:
- Macro: KBD_AUTOSEND_EN.
- Defined: a PRINT that fills the last slot (edit_len reaches MSG_CHARS) triggers an automatic commit in the following cycle, under the same slot-free rule as CR. If the slot is busy, the commit is retried each cycle until the slot frees; PRINT keystrokes still drop meanwhile.
- Not defined: a full buffer waits for CR or BS. Extra PRINTs drop.

Decomposition:
- Package kbd_msg_pkg holds:
  - constants ASCII_BS = 8'h08, ASCII_CR = 8'h0D, ASCII_SPACE = 8'h20, ASCII_PRINT_LO = 8'h20, ASCII_PRINT_HI = 8'h7E;
  - typedef char_t = logic [7:0];
  - enum msg_state_t {IDLE, PEND};
  - function char_class returning enum {CL_PRINT, CL_BS, CL_CR, CL_OTHER}.
- One sub-module, kbd_line_editor: owns the edit buffer, edit_len, and the PRINT/BS/full/drop logic. It exposes a commit request and a clear input.
- The top level owns the message register and the handshake FSM.

Test Plan (MSG_CHARS = 16 unless noted):
- Type "HI", then CR, msg_ready = 0 -> msg_valid = 1 one cycle after CR; msg_string top bytes = 8'h48, 8'h49, remaining 14 slots = 8'h20; msg_len = 2; edit_len = 0.
- Type "AB", BS, "C", CR -> msg_string = "AC" plus pad; msg_len = 2. A BS at edit_len = 0 leaves all outputs unchanged and drop = 0.
- Type 17 PRINT characters -> edit_len saturates at 16; drop pulses exactly once, on the 17th. With KBD_AUTOSEND_EN defined: commit after the 16th, msg_len = 16, and the 17th character lands in slot 0 of the new edit buffer.
- Commit "X" and hold msg_ready = 0; type "Y", CR -> drop pulses; msg_string still "X"; edit_len = 1. Then assert msg_ready and a CR in the same cycle -> msg_string = "Y", msg_valid stays 1.
- Input 8'h1B (OTHER) -> drop pulses, edit_len unchanged. A CR at edit_len = 0 -> no commit, no drop.
- Assert reset_n = 0 while in PEND with edit_len = 5 -> msg_valid drops asynchronously; all slots = 8'h20; both lengths = 0.
